// File: rtl/combat_judge.sv
// combat_judge: resolves hits between the two players, owns health/block
// counters, issues one-cycle hitFlag pulses and holds the match on KO.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   restart               level, accepted only while in KO
//   p1_state, p2_state    player current_state (player state encoding)
//   p*_basic_box          basic hitbox      {x1,x2,y1,y2}, 10 bits each
//   p*_dir_box            directional hitbox, same packing
//   p*_hurt_box           main hurtbox,       same packing
//   p*_hitFlag            00 none, 01 basic, 10 directional (registered pulse)
//   p*_health, p*_block   registered counters
//   game_over             high while in KO
//   winner                00 none, 01 P1, 10 P2, 11 draw
//
// Build option: define CHIP_DAMAGE_EN to make a blocked directional hit
// also remove 1 health (saturating, may cause KO).
module combat_judge #(
    parameter logic [2:0]  MAX_HEALTH  = 3'd7,
    parameter logic [2:0]  MAX_BLOCK   = 3'd3,
    parameter logic [2:0]  BASIC_DMG   = 3'd1,
    parameter logic [2:0]  DIR_DMG     = 3'd2,
    parameter int unsigned REGEN_TICKS = 60
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        restart,
    input  logic [3:0]  p1_state,
    input  logic [3:0]  p2_state,
    input  logic [39:0] p1_basic_box,
    input  logic [39:0] p2_basic_box,
    input  logic [39:0] p1_dir_box,
    input  logic [39:0] p2_dir_box,
    input  logic [39:0] p1_hurt_box,
    input  logic [39:0] p2_hurt_box,
    output logic [1:0]  p1_hitFlag,
    output logic [1:0]  p2_hitFlag,
    output logic [2:0]  p1_health,
    output logic [2:0]  p2_health,
    output logic [2:0]  p1_block,
    output logic [2:0]  p2_block,
    output logic        game_over,
    output logic [1:0]  winner
);

    localparam int unsigned CNT_W = 8;

    localparam logic [0:0] S_FIGHT = 1'b0;
    localparam logic [0:0] S_KO    = 1'b1;

    localparam logic [3:0] ST_MOVEBACK = 4'd2;
    localparam logic [3:0] ST_B_END    = 4'd4;
    localparam logic [3:0] ST_D_END    = 4'd7;
    localparam logic [3:0] ST_HITSTUN  = 4'd9;
    localparam logic [3:0] ST_NOREGEN  = 4'd10;

    // Inclusive rectangle overlap on both axes.
    function automatic logic f_overlap(input logic [39:0] a, input logic [39:0] b);
        return (a[39:30] <= b[29:20]) && (b[39:30] <= a[29:20]) &&
               (a[19:10] <= b[9:0])   && (b[19:10] <= a[9:0]);
    endfunction

    // Health after this cycle's incoming hit, saturating at 0.
    function automatic logic [2:0] f_health(input logic [2:0] h, input logic hit,
                                            input logic dir, input logic blocked);
        logic [2:0] dmg;
        dmg = 3'd0;
        if (hit) begin
            if (!blocked) begin
                dmg = dir ? DIR_DMG : BASIC_DMG;
            end
`ifdef CHIP_DAMAGE_EN
            else if (dir) begin
                dmg = 3'd1;
            end
`endif
        end
        return (h > dmg) ? (h - dmg) : 3'd0;
    endfunction

    // Block spend / regeneration; returns {block, regen_count}.
    function automatic logic [CNT_W+2:0] f_regen(input logic [2:0] blk,
                                                 input logic [CNT_W-1:0] cnt,
                                                 input logic [3:0] st,
                                                 input logic blocked);
        logic [2:0]       b;
        logic [CNT_W-1:0] c;
        b = blk;
        c = cnt;
        if (blocked) begin
            b = blk - 3'd1;
            c = '0;
        end else if ((st == ST_MOVEBACK) || (st == ST_NOREGEN)) begin
            c = '0;
        end else if (cnt == CNT_W'(REGEN_TICKS - 1)) begin
            c = '0;
            if (blk < MAX_BLOCK) begin
                b = blk + 3'd1;
            end
        end else begin
            c = cnt + CNT_W'(1);
        end
        return {b, c};
    endfunction

    logic [0:0]       r_state, w_state_nxt;
    logic [1:0]       r_p1_flag, r_p2_flag, w_p1_flag_nxt, w_p2_flag_nxt;
    logic [2:0]       r_p1_health, r_p2_health, w_p1_health_nxt, w_p2_health_nxt;
    logic [2:0]       r_p1_block, r_p2_block, w_p1_block_nxt, w_p2_block_nxt;
    logic [CNT_W-1:0] r_p1_cnt, r_p2_cnt, w_p1_cnt_nxt, w_p2_cnt_nxt;
    logic             r_p1_cons, r_p2_cons, w_p1_cons_nxt, w_p2_cons_nxt;
    logic             r_game_over, w_game_over_nxt;
    logic [1:0]       r_winner, w_winner_nxt;

    // Attack detection: pN_hits means player N lands a hit on the other.
    logic w_p1_att, w_p2_att, w_p1_dir, w_p2_dir;
    logic w_p1_hits, w_p2_hits, w_p1_blocked, w_p2_blocked;

    assign w_p1_dir = (p1_state == ST_D_END);
    assign w_p2_dir = (p2_state == ST_D_END);
    assign w_p1_att = (p1_state == ST_B_END) || w_p1_dir;
    assign w_p2_att = (p2_state == ST_B_END) || w_p2_dir;

    assign w_p1_hits = w_p1_att && !r_p1_cons && (r_state == S_FIGHT) &&
                       (p2_state != ST_HITSTUN) &&
                       f_overlap(w_p1_dir ? p1_dir_box : p1_basic_box, p2_hurt_box);
    assign w_p2_hits = w_p2_att && !r_p2_cons && (r_state == S_FIGHT) &&
                       (p1_state != ST_HITSTUN) &&
                       f_overlap(w_p2_dir ? p2_dir_box : p2_basic_box, p1_hurt_box);

    // pN_blocked: player N is the defender and spends a block charge.
    assign w_p1_blocked = w_p2_hits && (p1_state == ST_MOVEBACK) && (r_p1_block != 3'd0);
    assign w_p2_blocked = w_p1_hits && (p2_state == ST_MOVEBACK) && (r_p2_block != 3'd0);

    // Next-state and next-output logic.
    always_comb begin
        w_state_nxt     = r_state;
        w_p1_flag_nxt   = 2'b00;
        w_p2_flag_nxt   = 2'b00;
        w_p1_health_nxt = r_p1_health;
        w_p2_health_nxt = r_p2_health;
        w_p1_block_nxt  = r_p1_block;
        w_p2_block_nxt  = r_p2_block;
        w_p1_cnt_nxt    = r_p1_cnt;
        w_p2_cnt_nxt    = r_p2_cnt;
        w_game_over_nxt = r_game_over;
        w_winner_nxt    = r_winner;
        // One hit per swing: latch holds while the attacker stays in 4/7.
        w_p1_cons_nxt   = w_p1_att && (r_p1_cons || w_p1_hits);
        w_p2_cons_nxt   = w_p2_att && (r_p2_cons || w_p2_hits);

        case (r_state)
            S_FIGHT: begin
                if (w_p2_hits) begin
                    w_p1_flag_nxt = w_p2_dir ? 2'b10 : 2'b01;
                end
                if (w_p1_hits) begin
                    w_p2_flag_nxt = w_p1_dir ? 2'b10 : 2'b01;
                end
                w_p1_health_nxt = f_health(r_p1_health, w_p2_hits, w_p2_dir, w_p1_blocked);
                w_p2_health_nxt = f_health(r_p2_health, w_p1_hits, w_p1_dir, w_p2_blocked);
                {w_p1_block_nxt, w_p1_cnt_nxt} = f_regen(r_p1_block, r_p1_cnt, p1_state, w_p1_blocked);
                {w_p2_block_nxt, w_p2_cnt_nxt} = f_regen(r_p2_block, r_p2_cnt, p2_state, w_p2_blocked);
                if ((w_p1_health_nxt == 3'd0) || (w_p2_health_nxt == 3'd0)) begin
                    w_state_nxt     = S_KO;
                    w_game_over_nxt = 1'b1;
                    // Bit 1 set when P1 is down (P2 wins), bit 0 when P2 is down.
                    w_winner_nxt    = {w_p1_health_nxt == 3'd0, w_p2_health_nxt == 3'd0};
                end
            end
            S_KO: begin
                if (restart) begin
                    w_state_nxt     = S_FIGHT;
                    w_p1_health_nxt = MAX_HEALTH;
                    w_p2_health_nxt = MAX_HEALTH;
                    w_p1_block_nxt  = MAX_BLOCK;
                    w_p2_block_nxt  = MAX_BLOCK;
                    w_p1_cnt_nxt    = '0;
                    w_p2_cnt_nxt    = '0;
                    w_p1_cons_nxt   = 1'b0;
                    w_p2_cons_nxt   = 1'b0;
                    w_game_over_nxt = 1'b0;
                    w_winner_nxt    = 2'b00;
                end
            end
            default: begin
                w_state_nxt = S_FIGHT;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_FIGHT;
            r_p1_flag   <= 2'b00;
            r_p2_flag   <= 2'b00;
            r_p1_health <= MAX_HEALTH;
            r_p2_health <= MAX_HEALTH;
            r_p1_block  <= MAX_BLOCK;
            r_p2_block  <= MAX_BLOCK;
            r_p1_cnt    <= '0;
            r_p2_cnt    <= '0;
            r_p1_cons   <= 1'b0;
            r_p2_cons   <= 1'b0;
            r_game_over <= 1'b0;
            r_winner    <= 2'b00;
        end else begin
            r_state     <= w_state_nxt;
            r_p1_flag   <= w_p1_flag_nxt;
            r_p2_flag   <= w_p2_flag_nxt;
            r_p1_health <= w_p1_health_nxt;
            r_p2_health <= w_p2_health_nxt;
            r_p1_block  <= w_p1_block_nxt;
            r_p2_block  <= w_p2_block_nxt;
            r_p1_cnt    <= w_p1_cnt_nxt;
            r_p2_cnt    <= w_p2_cnt_nxt;
            r_p1_cons   <= w_p1_cons_nxt;
            r_p2_cons   <= w_p2_cons_nxt;
            r_game_over <= w_game_over_nxt;
            r_winner    <= w_winner_nxt;
        end
    end

    assign p1_hitFlag = r_p1_flag;
    assign p2_hitFlag = r_p2_flag;
    assign p1_health  = r_p1_health;
    assign p2_health  = r_p2_health;
    assign p1_block   = r_p1_block;
    assign p2_block   = r_p2_block;
    assign game_over  = r_game_over;
    assign winner     = r_winner;

endmodule

// File: tb/tb_combat_judge.sv
// Testbench for combat_judge: directed scenarios followed by randomized
// play, every output compared against a cycle-level rules model.
module tb_combat_judge;

    logic        clk;
    logic        rst_n;
    logic        restart;
    logic [3:0]  st   [2];
    logic [39:0] bbox [2];
    logic [39:0] dbox [2];
    logic [39:0] hurt [2];
    logic [1:0]  p1_hitFlag, p2_hitFlag;
    logic [2:0]  p1_health, p2_health, p1_block, p2_block;
    logic        game_over;
    logic [1:0]  winner;

    int errors = 0;
    int checks = 0;

    // Rules model state, index 0 = P1, 1 = P2.
    int m_h [2];
    int m_b [2];
    int m_c [2];
    int m_f [2];
    bit m_cons [2];
    bit m_ko;
    int m_win;

    combat_judge dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .restart      (restart),
        .p1_state     (st[0]),
        .p2_state     (st[1]),
        .p1_basic_box (bbox[0]),
        .p2_basic_box (bbox[1]),
        .p1_dir_box   (dbox[0]),
        .p2_dir_box   (dbox[1]),
        .p1_hurt_box  (hurt[0]),
        .p2_hurt_box  (hurt[1]),
        .p1_hitFlag   (p1_hitFlag),
        .p2_hitFlag   (p2_hitFlag),
        .p1_health    (p1_health),
        .p2_health    (p2_health),
        .p1_block     (p1_block),
        .p2_block     (p2_block),
        .game_over    (game_over),
        .winner       (winner)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [39:0] mk(input int x1, input int x2, input int y1, input int y2);
        return {10'(x1), 10'(x2), 10'(y1), 10'(y2)};
    endfunction

    function automatic bit overlaps(input logic [39:0] a, input logic [39:0] b);
        int ax1, ax2, ay1, ay2, bx1, bx2, by1, by2;
        ax1 = int'(a[39:30]); ax2 = int'(a[29:20]); ay1 = int'(a[19:10]); ay2 = int'(a[9:0]);
        bx1 = int'(b[39:30]); bx2 = int'(b[29:20]); by1 = int'(b[19:10]); by2 = int'(b[9:0]);
        return (ax1 <= bx2) && (bx1 <= ax2) && (ay1 <= by2) && (by1 <= ay2);
    endfunction

    function automatic int max0(input int x);
        return (x < 0) ? 0 : x;
    endfunction

    task automatic model_reset();
        for (int p = 0; p < 2; p++) begin
            m_h[p] = 7; m_b[p] = 3; m_c[p] = 0; m_f[p] = 0; m_cons[p] = 1'b0;
        end
        m_ko = 1'b0;
        m_win = 0;
    endtask

    // One clock edge of the match rules, from the inputs present at the edge.
    task automatic model_edge();
        int nh [2];
        int nb [2];
        int nc [2];
        int nf [2];
        bit hit [2];
        bit isdir [2];
        bit ncons [2];
        bit att;
        if (!rst_n) begin
            model_reset();
            return;
        end
        for (int a = 0; a < 2; a++) begin
            att = (st[a] == 4) || (st[a] == 7);
            isdir[a] = (st[a] == 7);
            hit[a] = !m_ko && att && !m_cons[a] && (st[1-a] != 9) &&
                     overlaps(isdir[a] ? dbox[a] : bbox[a], hurt[1-a]);
            ncons[a] = att && (m_cons[a] || hit[a]);
        end
        for (int d = 0; d < 2; d++) begin
            int a;
            bit used;
            a = 1 - d;
            nf[d] = 0; nh[d] = m_h[d]; nb[d] = m_b[d]; nc[d] = m_c[d]; used = 1'b0;
            if (!m_ko) begin
                if (hit[a]) begin
                    nf[d] = isdir[a] ? 2 : 1;
                    if (st[d] == 2 && m_b[d] > 0) begin
                        used = 1'b1;
                        nb[d] = nb[d] - 1;
`ifdef CHIP_DAMAGE_EN
                        if (isdir[a]) nh[d] = max0(nh[d] - 1);
`endif
                    end else begin
                        nh[d] = max0(nh[d] - (isdir[a] ? 2 : 1));
                    end
                end
                if (used || st[d] == 2 || st[d] == 10) begin
                    nc[d] = 0;
                end else begin
                    nc[d] = nc[d] + 1;
                    if (nc[d] == 60) begin
                        nc[d] = 0;
                        if (nb[d] < 3) nb[d] = nb[d] + 1;
                    end
                end
            end
        end
        for (int p = 0; p < 2; p++) begin
            m_h[p] = nh[p]; m_b[p] = nb[p]; m_c[p] = nc[p]; m_f[p] = nf[p]; m_cons[p] = ncons[p];
        end
        if (!m_ko) begin
            if (nh[0] == 0 || nh[1] == 0) begin
                m_ko = 1'b1;
                m_win = (nh[0] == 0 && nh[1] == 0) ? 3 : ((nh[1] == 0) ? 1 : 2);
            end
        end else if (restart) begin
            model_reset();
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".p1_flag"},   8'(p1_hitFlag), 8'(m_f[0]));
        chk({tag, ".p2_flag"},   8'(p2_hitFlag), 8'(m_f[1]));
        chk({tag, ".p1_health"}, 8'(p1_health),  8'(m_h[0]));
        chk({tag, ".p2_health"}, 8'(p2_health),  8'(m_h[1]));
        chk({tag, ".p1_block"},  8'(p1_block),   8'(m_b[0]));
        chk({tag, ".p2_block"},  8'(p2_block),   8'(m_b[1]));
        chk({tag, ".game_over"}, 8'(game_over),  8'(m_ko));
        chk({tag, ".winner"},    8'(winner),     8'(m_win));
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic default_boxes();
        bbox[0] = mk(100, 150, 100, 150);
        dbox[0] = mk(100, 150, 100, 150);
        hurt[1] = mk(140, 200, 100, 200);
        bbox[1] = mk(500, 550, 500, 550);
        dbox[1] = mk(500, 550, 500, 550);
        hurt[0] = mk(0, 50, 0, 50);
    endtask

    initial begin
        rst_n = 1'b1;
        restart = 1'b0;
        st[0] = 4'd0;
        st[1] = 4'd0;
        default_boxes();

        // Reset values, asserted asynchronously before any clock edge.
        #1 rst_n = 1'b0;
        #2;
        model_reset();
        check_all("reset");
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Basic hit, then no repeat while the swing continues.
        st[0] = 4'd4;
        step("basic");
        chk("basic_flag", 8'(p2_hitFlag), 8'd1);
        chk("basic_health", 8'(p2_health), 8'd6);
        step("basic_hold");
        chk("basic_hold_flag", 8'(p2_hitFlag), 8'd0);
        st[0] = 4'd0;
        step("basic_release");

        // Blocked directional hit.
        st[1] = 4'd2;
        st[0] = 4'd7;
        step("block");
        chk("block_flag", 8'(p2_hitFlag), 8'd2);
        chk("block_block", 8'(p2_block), 8'd2);
`ifdef CHIP_DAMAGE_EN
        chk("block_health", 8'(p2_health), 8'd5);
`else
        chk("block_health", 8'(p2_health), 8'd6);
`endif

        // Regeneration: exactly 60 idle cycles for +1.
        st[0] = 4'd0;
        st[1] = 4'd0;
        for (int i = 0; i < 59; i++) step("regen_wait");
        chk("regen_59", 8'(p2_block), 8'd2);
        step("regen_tick");
        chk("regen_60", 8'(p2_block), 8'd3);
        for (int i = 0; i < 100; i++) step("regen_full");
        chk("regen_cap", 8'(p2_block), 8'd3);

        // No regeneration while moving backwards.
        st[1] = 4'd2;
        st[0] = 4'd7;
        step("block2");
        st[0] = 4'd0;
        for (int i = 0; i < 100; i++) step("noregen");
        chk("noregen_block", 8'(p2_block), 8'd2);

        // Hitstun invulnerability; the ignored overlap does not consume the swing.
        st[1] = 4'd9;
        st[0] = 4'd4;
        step("stun");
        chk("stun_flag", 8'(p2_hitFlag), 8'd0);
        st[1] = 4'd0;
        step("after_stun");
        chk("after_stun_flag", 8'(p2_hitFlag), 8'd1);
        st[0] = 4'd0;
        step("stun_release");

        // Edge separation: one pixel apart misses, touching edges hit.
        bbox[0] = mk(100, 140, 100, 150);
        hurt[1] = mk(141, 200, 100, 200);
        st[0] = 4'd4;
        step("gap");
        chk("gap_flag", 8'(p2_hitFlag), 8'd0);
        hurt[1] = mk(140, 200, 100, 200);
        step("touch");
        chk("touch_flag", 8'(p2_hitFlag), 8'd1);
        st[0] = 4'd0;
        step("touch_release");

        // Asynchronous reset mid-fight.
        rst_n = 1'b0;
        #2;
        model_reset();
        check_all("async_reset");
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Trade down to 1 health each, then a mutual KO.
        default_boxes();
        hurt[0] = mk(120, 160, 120, 160);
        dbox[1] = mk(150, 170, 150, 170);
        for (int k = 0; k < 3; k++) begin
            st[0] = 4'd7; st[1] = 4'd7;
            step("trade");
            st[0] = 4'd0; st[1] = 4'd0;
            step("trade_gap");
        end
        chk("trade_p1_h1", 8'(p1_health), 8'd1);
        chk("trade_p2_h1", 8'(p2_health), 8'd1);
        st[0] = 4'd7; st[1] = 4'd7;
        restart = 1'b1;
        step("trade_ko");
        chk("ko_p1_health", 8'(p1_health), 8'd0);
        chk("ko_p2_health", 8'(p2_health), 8'd0);
        chk("ko_game_over", 8'(game_over), 8'd1);
        chk("ko_winner", 8'(winner), 8'd3);
        restart = 1'b0;
        step("ko_hold");
        step("ko_hold2");
        chk("ko_hold_flag", 8'(p1_hitFlag), 8'd0);
        st[0] = 4'd0; st[1] = 4'd0;
        restart = 1'b1;
        step("restart");
        chk("restart_health", 8'(p1_health), 8'd7);
        chk("restart_block", 8'(p2_block), 8'd3);
        chk("restart_winner", 8'(winner), 8'd0);
        restart = 1'b0;
        step("post_restart");

        // Randomized play against the rules model.
        for (int i = 0; i < 600; i++) begin
            rst_n = ($urandom_range(0, 149) != 0);
            restart = ($urandom_range(0, 5) == 0);
            for (int p = 0; p < 2; p++) begin
                int x, y;
                if ($urandom_range(0, 9) < 4) begin
                    if ($urandom_range(0, 1) == 1)
                        st[p] = ($urandom_range(0, 1) == 1) ? 4'd4 : 4'd7;
                    else
                        st[p] = 4'($urandom_range(0, 11));
                end
                x = $urandom_range(0, 60); y = $urandom_range(0, 60);
                bbox[p] = mk(x, x + $urandom_range(0, 30), y, y + $urandom_range(0, 30));
                x = $urandom_range(0, 60); y = $urandom_range(0, 60);
                dbox[p] = mk(x, x + $urandom_range(0, 30), y, y + $urandom_range(0, 30));
                x = $urandom_range(0, 60); y = $urandom_range(0, 60);
                hurt[p] = mk(x, x + $urandom_range(0, 30), y, y + $urandom_range(0, 30));
            end
            step("rnd");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/combat_judge.md
# combat_judge

Resolves combat between the two player FSMs: each cycle it checks the attacker's active hitbox against the defender's main hurtbox, issues the one-cycle `hitFlag` pulse to the struck player, and owns both players' `health` and `block` counters. It sits between the two `player` instances and the renderer/HUD. It is the producing end of the `hitFlag`/`health`/`block` inputs that each player consumes. It also detects KO and holds the match until restart.

## Interface
Parameters:
- MAX_HEALTH, 7: health value at reset and restart; 3-bit.
- MAX_BLOCK, 3: block value at reset and restart; 3-bit.
- BASIC_DMG, 1: health lost on an unblocked basic hit.
- DIR_DMG, 2: health lost on an unblocked directional hit.
- REGEN_TICKS, 60: idle cycles per +1 block regeneration; 1..255.

Ports:
- clk  in  1  system/frame clock, the same one that drives the players.
- rst_n  in  1  asynchronous, active-low reset.
- restart  in  1  level; accepted only in S_KO.
- p1_state, p2_state  in  4 each  player `current_state`, using the player state encoding.
- p1_basic_box, p2_basic_box  in  40 each  packed {x1,x2,y1,y2}, 10 bits each.
- p1_dir_box, p2_dir_box  in  40 each  directional hitbox, same packing.
- p1_hurt_box, p2_hurt_box  in  40 each  main hurtbox, same packing.
- p1_hitFlag, p2_hitFlag  out  2 each  00 none, 01 basic, 10 directional; registered.
- p1_health, p2_health  out  3 each  registered.
- p1_block, p2_block  out  3 each  registered.
- game_over  out  1  high in S_KO.
- winner  out  2  00 none, 01 P1, 10 P2, 11 draw.

## Operation
- FSM states:
  - S_FIGHT: reset state.
  - S_KO: entered when either health reaches 0 on a clock edge. Returns to S_FIGHT when `restart`=1. On that return, health goes to MAX_HEALTH and block goes to MAX_BLOCK, and all latches and counters clear.
- Active hitbox:
  - Attacker state 4 (B_ATTACK_END) uses the basic box.
  - Attacker state 7 (D_ATTACK_END) uses the directional box.
  - Every other state has no hitbox.
- Overlap test, inclusive on both axes: a.x1<=b.x2 && b.x1<=a.x2 && a.y1<=b.y2 && b.y1<=a.y2.
- One hit per swing:
  - A per-attacker `consumed` latch is set when a hit resolves.
  - The latch clears when the attacker leaves state 4/7.
- The defender is invulnerable in state 9 (HITSTUN). Overlaps against it are ignored and do not set `consumed`.
- Resolution applies when there is an overlap, the latch is clear, the match is in S_FIGHT, and the defender is not in state 9:
  - Defender hitFlag is set to 01 (basic) or 10 (directional) for exactly one cycle.
  - If the defender is in state 2 (MOVEBACKWARDS) and block>0: the hit is blocked, block decrements by 1 and health is unchanged.
  - Otherwise health is reduced by BASIC_DMG or DIR_DMG, saturating at 0.
- Simultaneous hits (trade): both resolve on the same edge. If both health values reach 0, winner=11.
- Block regeneration, per player:
  - A counter increments each cycle the player is not in state 2 or 10.
  - At REGEN_TICKS, block increments by 1 (only if block<MAX_BLOCK) and the counter clears.
  - The counter clears on any block use and whenever the player is in state 2 or 10.
- In S_KO: hitFlags are forced to 00, health and block are frozen, and winner is held.

## Timing
- Reset values: hitFlags=00, health=MAX_HEALTH, block=MAX_BLOCK, game_over=0, winner=00, FSM=S_FIGHT, latches and counters at 0.
- Latency, measured from the edge on which the overlap is sampled:
  - hitFlag, health and block update on the next clk edge (1 cycle).
  - The player consumes hitFlag on the following edge.
- hitFlag is a one-cycle pulse. It is never held across two consecutive cycles for the same swing.
- game_over and winner assert on the same edge as the fatal health update.
- `restart` is sampled only in S_KO. restart=1 on the KO-entry edge itself has no effect.
- An rst_n assertion at any point, including mid-stun or mid-KO, immediately restores the reset values.

## Configuration
- CHIP_DAMAGE_EN defined: a blocked directional hit also deducts 1 health (saturating) and can KO. Blocked basic hits deduct no health.
- CHIP_DAMAGE_EN undefined: blocked hits never change health.

## Test plan
- Basic hit: P1 state=4, boxes overlapping, P2 state=0. Required response: p2_hitFlag=01 for 1 cycle and p2_health 7->6. A second cycle in state 4 produces no further hit.
- Block: P2 state=2 with block=3, P1 state=7 overlapping. Required response: p2_hitFlag=10, p2_block 3->2, p2_health stays 7. With CHIP_DAMAGE_EN, p2_health 7->6.
- Regeneration: p2_block=2, P2 held in state 0. Required response: block=3 after exactly 60 cycles and no change after that; state 2 held for 100 cycles gives no regeneration.
- Trade KO: both health=1, both players attacking with a mutual overlap on the same cycle. Required response: both health=0, game_over=1, winner=11.
- Stun and separation: P2 in state 9 while P1's hitbox overlaps gives hitFlag=00 and no damage. A basic hit on P2 with x1 exactly equal to the other box's x2 registers a hit.
- Restart/reset: from KO, restart=1 gives health=7, block=3, winner=00 on the next edge. rst_n=0 during S_FIGHT restores reset values asynchronously.
